// File: rtl/jump_ctrl.sv
// jump_ctrl: button conditioning (2-FF sync + ms-tick debounce), free-running
// 1 ms tick, and single-cycle jump requests with one jump in flight and a
// single buffered request re-armed by the character's landed pulse.
module jump_ctrl #(
  parameter int CLK_FREQ_HZ    = 40000000,
  parameter int DEBOUNCE_MS    = 10,
  parameter int AIR_TIMEOUT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic game_en,
  input  logic btn_left,
  input  logic btn_right,
  input  logic landed,
  output logic one_ms_tick,
  output logic jump_left,
  output logic jump_right,
  output logic busy
);

  localparam int          DIV       = CLK_FREQ_HZ / 1000;
  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
  localparam logic [7:0]  DEB_LIMIT = 8'(DEBOUNCE_MS);
  localparam logic [9:0]  AIR_LIMIT = 10'(AIR_TIMEOUT_MS);

  typedef enum logic {
    S_READY = 1'b0,
    S_AIR   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    P_NONE  = 2'd0,
    P_LEFT  = 2'd1,
    P_RIGHT = 2'd2
  } pend_t;

  // ---------------------------------------------------------------------------
  // 1 ms tick
  // ---------------------------------------------------------------------------
  logic [15:0] tick_cnt_reg;
  logic        tick_reg;

  // Divider wraps at DIV-1; the registered tick fires on the DIV-th clock after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg <= 16'd0;
      tick_reg     <= 1'b0;
    end else begin
      tick_reg     <= (tick_cnt_reg == DIV_LAST);
      tick_cnt_reg <= (tick_cnt_reg == DIV_LAST) ? 16'd0 : tick_cnt_reg + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button synchroniser, debounce and press-event detection
  // bit 0 = left, bit 1 = right
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] press_evt;

  assign btn_raw = {btn_right, btn_left};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic       meta_reg;
      logic       sync_reg;
      logic       stable_reg;
      logic       stable_d_reg;
      logic       press_reg;
      logic [7:0] deb_cnt_reg;

      // Sync the raw level, accept a new level after DEBOUNCE_MS ticks, flag rising edges.
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg     <= 1'b0;
          sync_reg     <= 1'b0;
          stable_reg   <= 1'b0;
          stable_d_reg <= 1'b0;
          press_reg    <= 1'b0;
          deb_cnt_reg  <= 8'd0;
        end else begin
          meta_reg     <= btn_raw[gi];
          sync_reg     <= meta_reg;
          stable_d_reg <= stable_reg;
          press_reg    <= stable_reg & ~stable_d_reg;
          if (sync_reg == stable_reg) begin
            deb_cnt_reg <= 8'd0;
          end else if (tick_reg) begin
            if (deb_cnt_reg + 8'd1 == DEB_LIMIT) begin
              stable_reg  <= sync_reg;
              deb_cnt_reg <= 8'd0;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + 8'd1;
            end
          end
        end
      end

      assign press_evt[gi] = press_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Jump FSM
  // ---------------------------------------------------------------------------
  state_t     state_reg, state_next;
  pend_t      pend_reg, pend_next, pend_cap;
  logic [9:0] air_reg, air_next;
  logic       jump_left_reg, jump_right_reg, busy_reg;
  logic       jl_next, jr_next;
  logic       single_l, single_r, jump_guard;

  // Presses on both buttons in the same cycle cancel each other.
  assign single_l   = press_evt[0] & ~press_evt[1];
  assign single_r   = press_evt[1] & ~press_evt[0];
  // A landed arriving right after a pulse is ignored so pulses never abut.
  assign jump_guard = jump_left_reg | jump_right_reg;

  // Next state, buffered request, air timer and jump pulses.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    air_next   = air_reg;
    jl_next    = 1'b0;
    jr_next    = 1'b0;
    pend_cap   = pend_reg;

    // A press in the landing cycle is captured before landed consumes it.
    if (pend_reg == P_NONE) begin
      if (single_l)      pend_cap = P_LEFT;
      else if (single_r) pend_cap = P_RIGHT;
    end

    if (!game_en) begin
      state_next = S_READY;
      pend_next  = P_NONE;
      air_next   = 10'd0;
    end else begin
      case (state_reg)
        S_READY: begin
          if (single_l || single_r) begin
            jl_next    = single_l;
            jr_next    = single_r;
            state_next = S_AIR;
            air_next   = 10'd0;
          end
        end
        S_AIR: begin
          if (landed && !jump_guard) begin
            air_next  = 10'd0;
            pend_next = P_NONE;
            if (pend_cap != P_NONE) begin
              jl_next = (pend_cap == P_LEFT);
              jr_next = (pend_cap == P_RIGHT);
            end else begin
              state_next = S_READY;
            end
          end else if (tick_reg && (air_reg + 10'd1 == AIR_LIMIT)) begin
            state_next = S_READY;
            pend_next  = P_NONE;
            air_next   = 10'd0;
          end else begin
            pend_next = pend_cap;
            if (tick_reg) air_next = air_reg + 10'd1;
          end
        end
        default: begin
          state_next = S_READY;
          pend_next  = P_NONE;
          air_next   = 10'd0;
        end
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_READY;
      pend_reg       <= P_NONE;
      air_reg        <= 10'd0;
      jump_left_reg  <= 1'b0;
      jump_right_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_reg       <= pend_next;
      air_reg        <= air_next;
      jump_left_reg  <= jl_next;
      jump_right_reg <= jr_next;
      busy_reg       <= (state_next == S_AIR);
    end
  end

  assign one_ms_tick = tick_reg;
  assign jump_left   = jump_left_reg;
  assign jump_right  = jump_right_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_jump_ctrl.sv
// Testbench for jump_ctrl: directed scenarios plus randomized stimulus, all
// checked cycle by cycle against a behavioural model of the jump rules.
module tb_jump_ctrl;

  localparam int CLK_FREQ_HZ    = 10000;
  localparam int DEBOUNCE_MS    = 3;
  localparam int AIR_TIMEOUT_MS = 20;
  localparam int DIV            = CLK_FREQ_HZ / 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_en = 1'b1;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic landed = 1'b0;
  logic one_ms_tick, jump_left, jump_right, busy;

  jump_ctrl #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .DEBOUNCE_MS   (DEBOUNCE_MS),
    .AIR_TIMEOUT_MS(AIR_TIMEOUT_MS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_en    (game_en),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .landed     (landed),
    .one_ms_tick(one_ms_tick),
    .jump_left  (jump_left),
    .jump_right (jump_right),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   cnt_jl = 0;
  int   cnt_jr = 0;
  logic prev_j = 1'b0;

  // ---------------- behavioural model ----------------
  // Model time is "after each rising edge". Buttons pass through a two-stage
  // delay, a level is accepted once it has differed for DEBOUNCE_MS ticks, and
  // an accepted rise becomes a press one cycle later.
  int m_div;
  int m_tick;
  int m_hist[2][2];     // [button][0]=first stage, [1]=synchronised
  int m_level[2];       // accepted level
  int m_level_old[2];   // accepted level one cycle ago
  int m_ms_seen[2];     // ticks seen while sync differs from accepted level
  int m_press[2];
  int m_in_air;
  int m_want;           // 0 none, 1 left, 2 right
  int m_ms_air;
  int m_jl, m_jr;

  task automatic model_reset();
    m_div = 0; m_tick = 0; m_in_air = 0; m_want = 0; m_ms_air = 0;
    m_jl = 0; m_jr = 0;
    for (int b = 0; b < 2; b++) begin
      m_hist[b][0] = 0; m_hist[b][1] = 0; m_level[b] = 0;
      m_level_old[b] = 0; m_ms_seen[b] = 0; m_press[b] = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic bl,
                            input logic br, input logic ld);
    int raw[2];
    int was_tick, lone, cand, just_jumped;
    int pr[2];
    if (r) begin
      model_reset();
      return;
    end
    raw[0] = int'(bl); raw[1] = int'(br);
    was_tick    = m_tick;
    just_jumped = m_jl + m_jr;
    pr[0] = m_press[0]; pr[1] = m_press[1];

    m_tick = (m_div == DIV - 1) ? 1 : 0;
    m_div  = (m_div + 1) % DIV;

    for (int b = 0; b < 2; b++) begin
      m_press[b]     = (m_level[b] == 1 && m_level_old[b] == 0) ? 1 : 0;
      m_level_old[b] = m_level[b];
      if (m_hist[b][1] == m_level[b]) m_ms_seen[b] = 0;
      else if (was_tick == 1) begin
        m_ms_seen[b]++;
        if (m_ms_seen[b] == DEBOUNCE_MS) begin
          m_level[b]   = m_hist[b][1];
          m_ms_seen[b] = 0;
        end
      end
      m_hist[b][1] = m_hist[b][0];
      m_hist[b][0] = raw[b];
    end

    lone = (pr[0] == 1 && pr[1] == 0) ? 1 : (pr[1] == 1 && pr[0] == 0) ? 2 : 0;
    m_jl = 0; m_jr = 0;
    if (!en) begin
      m_in_air = 0; m_want = 0; m_ms_air = 0;
    end else if (m_in_air == 0) begin
      if (lone != 0) begin
        m_jl = (lone == 1); m_jr = (lone == 2);
        m_in_air = 1; m_ms_air = 0;
      end
    end else begin
      cand = (m_want != 0) ? m_want : lone;
      if (ld && just_jumped == 0) begin
        if (cand != 0) begin
          m_jl = (cand == 1); m_jr = (cand == 2);
        end else begin
          m_in_air = 0;
        end
        m_want = 0; m_ms_air = 0;
      end else if (was_tick == 1 && m_ms_air + 1 == AIR_TIMEOUT_MS) begin
        m_in_air = 0; m_want = 0; m_ms_air = 0;
      end else begin
        m_want = cand;
        m_ms_air += was_tick;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive at negedge, advance model, sample 1 ns after posedge.
  task automatic step(input logic r, input logic en, input logic bl,
                      input logic br, input logic ld);
    @(negedge clk);
    rst = r; game_en = en; btn_left = bl; btn_right = br; landed = ld;
    model_step(r, en, bl, br, ld);
    @(posedge clk);
    #1;
    cyc++;
    check("tick", 32'(one_ms_tick), 32'(m_tick));
    check("jump_left", 32'(jump_left), 32'(m_jl));
    check("jump_right", 32'(jump_right), 32'(m_jr));
    check("busy", 32'(busy), 32'(m_in_air));
    check("jump_excl", 32'(jump_left & jump_right), 32'd0);
    check("jump_gap", 32'(prev_j & (jump_left | jump_right)), 32'd0);
    prev_j = jump_left | jump_right;
    if (jump_left)  begin cnt_jl++; $display("cycle %0d: jump_left  busy=%0b", cyc, busy); end
    if (jump_right) begin cnt_jr++; $display("cycle %0d: jump_right busy=%0b", cyc, busy); end
  endtask

  task automatic hold(input logic bl, input logic br, input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, en, bl, br, 1'b0);
  endtask

  // After reset has been applied: first tick on the 10th clock, then every 10.
  task automatic tick_after_reset();
    int first_tick = -1;
    int n_ticks = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (one_ms_tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    check("first_tick_cycle", 32'(first_tick), 32'd10);
    check("tick_count_30", 32'(n_ticks), 32'd3);
  endtask

  initial begin
    model_reset();

    // Reset state and tick timing
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_tick", 32'(one_ms_tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_jumps", 32'({jump_left, jump_right}), 32'd0);
    tick_after_reset();

    // Debounce: 2 ms glitch rejected, 5 ms hold accepted once
    cnt_jl = 0;
    hold(1'b1, 1'b0, 20, 1'b1);
    hold(1'b0, 1'b0, 60, 1'b1);
    check("glitch_no_jump", 32'(cnt_jl), 32'd0);
    hold(1'b1, 1'b0, 50, 1'b1);
    hold(1'b0, 1'b0, 20, 1'b1);
    check("debounced_jump", 32'(cnt_jl), 32'd1);
    check("busy_in_air", 32'(busy), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("landed_rearm", 32'(busy), 32'd0);

    // Buffered jump released by landed
    cnt_jl = 0; cnt_jr = 0;
    hold(1'b0, 1'b1, 50, 1'b1);
    hold(1'b0, 1'b0, 40, 1'b1);
    check("buf_first_right", 32'(cnt_jr), 32'd1);
    hold(1'b1, 1'b0, 50, 1'b1);
    hold(1'b0, 1'b0, 40, 1'b1);
    check("buf_held_pending", 32'(cnt_jl), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("buf_left_after_landed", 32'(jump_left), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("buf_busy_stays", 32'(busy), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("buf_second_landed_idle", 32'(busy), 32'd0);

    // Lockout and air timeout discard the buffered request
    cnt_jl = 0; cnt_jr = 0;
    hold(1'b1, 1'b0, 50, 1'b1);
    hold(1'b0, 1'b1, 40, 1'b1);
    hold(1'b0, 1'b0, 30, 1'b1);
    hold(1'b0, 1'b1, 40, 1'b1);
    hold(1'b0, 1'b0, 110, 1'b1);
    check("timeout_one_jump", 32'(cnt_jl), 32'd1);
    check("timeout_no_right", 32'(cnt_jr), 32'd0);
    check("timeout_busy_low", 32'(busy), 32'd0);

    // Simultaneous presses and game_en gating
    cnt_jl = 0; cnt_jr = 0;
    hold(1'b1, 1'b1, 50, 1'b1);
    hold(1'b0, 1'b0, 40, 1'b1);
    check("simul_no_jump", 32'(cnt_jl + cnt_jr), 32'd0);
    hold(1'b1, 1'b0, 50, 1'b0);
    hold(1'b0, 1'b0, 40, 1'b0);
    check("disabled_no_jump", 32'(cnt_jl), 32'd0);
    hold(1'b1, 1'b0, 50, 1'b1);
    hold(1'b0, 1'b0, 10, 1'b1);
    hold(1'b0, 1'b1, 40, 1'b1);
    hold(1'b0, 1'b0, 40, 1'b1);
    check("en_drop_setup", 32'(cnt_jl), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("en_drop_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    hold(1'b0, 1'b0, 5, 1'b1);
    check("en_drop_no_jump", 32'(cnt_jr), 32'd0);

    // Reset mid-air with a request pending
    cnt_jl = 0;
    hold(1'b1, 1'b0, 50, 1'b1);
    hold(1'b0, 1'b0, 10, 1'b1);
    hold(1'b0, 1'b1, 40, 1'b1);
    hold(1'b0, 1'b0, 40, 1'b1);
    check("rst_air_setup", 32'(busy), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_air_outputs", 32'({one_ms_tick, jump_left, jump_right, busy}), 32'd0);
    tick_after_reset();

    // Randomized segments against the model
    for (int seg = 0; seg < 150; seg++) begin
      logic en, bl, br;
      int   len;
      if ($urandom_range(0, 49) == 0) begin
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      en  = ($urandom_range(0, 9) != 0);
      bl  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        step(1'b0, en, bl, br, ($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
